// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
//   Bundles the three sides of the store buffer into one interface:
//     st_*   : store request from the execute/memory stage (valid/ready),
//              plus the one-cycle st_error drop indication
//     mem_*  : write port towards data memory / MMIO (valid/ready)
//     ld_*   : same-stage load address and the resulting hazard flag
//     count / empty : occupancy status
//   Modports:
//     slave  : the store buffer's own view (consumes stores, drives memory)
//     master : the surrounding pipeline / memory view
// -----------------------------------------------------------------------------
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [2:0]       st_funct3;
    logic             st_error;

    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_we;

    logic [31:0]      ld_addr;
    logic             ld_hazard;

    logic [CNT_W-1:0] count;
    logic             empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3,
        output st_ready, st_error,
        output mem_valid, mem_addr, mem_wdata, mem_we,
        input  mem_ready,
        input  ld_addr,
        output ld_hazard,
        output count, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_funct3,
        input  st_ready, st_error,
        input  mem_valid, mem_addr, mem_wdata, mem_we,
        output mem_ready,
        output ld_addr,
        input  ld_hazard,
        input  count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Write-side formatter and queue for RISC-V sb/sh/sw. An accepted store is
//   lane-replicated and given a byte-write-enable; legal stores are queued in
//   a DEPTH-entry FIFO and drained in order to memory, illegal ones
//   (misaligned or undefined funct3) are consumed and flagged on st_error the
//   following cycle. A same-stage load is flagged when any pending entry
//   targets its word.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset, discards all pending stores
//     bus    : store_buffer_if.slave (store request, memory port, load
//              hazard check, occupancy)
//
//   Parameters:
//     DEPTH  : FIFO entries, power of two in 2..16
//     CNT_W  : width of the occupancy count
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } entry_t;

    // Payload storage is not reset: every consumer is gated by valid_q or by
    // count_q, so stale payload is never observable.
    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             st_error_q, st_error_d;

    logic             st_ready;
    logic             accept;
    logic             enq;
    logic             deq;
    logic             fmt_legal;
    logic [31:0]      fmt_wdata;
    logic [3:0]       fmt_we;
    logic             hazard;

    // st_ready depends on registered occupancy only, so a full buffer stays
    // closed even in a cycle where the head is being drained.
    assign st_ready = (count_q < CNT_W'(DEPTH));
    assign accept   = bus.st_valid && st_ready;
    assign enq      = accept && fmt_legal;
    assign deq      = (count_q != '0) && bus.mem_ready;

    // Store formatting: replicate data into every lane, select the lanes
    // written with the byte-write-enable.
    always_comb begin
        fmt_legal = 1'b0;
        fmt_wdata = bus.st_data;
        fmt_we    = 4'b0000;
        case (bus.st_funct3)
            3'b000: begin
                fmt_wdata = {4{bus.st_data[7:0]}};
                fmt_we    = 4'b0001 << bus.st_addr[1:0];
                fmt_legal = 1'b1;
            end
            3'b001: begin
                fmt_wdata = {2{bus.st_data[15:0]}};
                fmt_we    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_legal = !bus.st_addr[0];
            end
            3'b010: begin
                fmt_wdata = bus.st_data;
                fmt_we    = 4'b1111;
                fmt_legal = (bus.st_addr[1:0] == 2'b00);
            end
            default: begin
                fmt_legal = 1'b0;
            end
        endcase
    end

    // Queue next-state. enq and deq never touch the same slot in one cycle:
    // enq needs count < DEPTH and deq needs count > 0, and the pointers only
    // coincide when the count is 0 or DEPTH.
    always_comb begin
        entry_d    = entry_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        st_error_d = accept && !fmt_legal;

        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        if (enq) begin
            entry_d[wr_ptr_q].addr  = bus.st_addr[31:2];
            entry_d[wr_ptr_q].wdata = fmt_wdata;
            entry_d[wr_ptr_q].we    = fmt_we;
            valid_d[wr_ptr_q]       = 1'b1;
            wr_ptr_d                = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            st_error_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            st_error_q <= st_error_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    // Word-granular match against every pending entry; a store being
    // accepted this same cycle is deliberately not considered.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].addr == bus.ld_addr[31:2])) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.st_ready  = st_ready;
    assign bus.st_error  = st_error_q;
    assign bus.mem_valid = (count_q != '0);
    assign bus.mem_addr  = {entry_q[rd_ptr_q].addr, 2'b00};
    assign bus.mem_wdata = entry_q[rd_ptr_q].wdata;
    assign bus.mem_we    = entry_q[rd_ptr_q].we;
    assign bus.ld_hazard = hazard;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    store_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending stores as a plain queue in acceptance order.
    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } exp_t;

    exp_t q[$];
    bit   exp_err;

    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = m_size(f3);
        if (sz == 0) return 1'b0;
        return (addr % sz) == 0;
    endfunction

    function automatic logic [3:0] m_we(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        int mask;
        sz   = m_size(f3);
        mask = ((1 << sz) - 1) << (addr % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w;
        int sz;
        sz = m_size(f3);
        w  = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % sz) +: 8];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit hz;
        hz = 1'b0;
        foreach (q[i]) if (q[i].a == bus.ld_addr[31:2]) hz = 1'b1;
        chk("count",     32'(bus.count),    32'(q.size()));
        chk("empty",     32'(bus.empty),    32'(q.size() == 0));
        chk("st_ready",  32'(bus.st_ready), 32'(q.size() < DEPTH));
        chk("mem_valid", 32'(bus.mem_valid), 32'(q.size() != 0));
        chk("st_error",  32'(bus.st_error), 32'(exp_err));
        chk("ld_hazard", 32'(bus.ld_hazard), 32'(hz));
        if (q.size() != 0) begin
            chk("mem_addr",  bus.mem_addr,     {q[0].a, 2'b00});
            chk("mem_wdata", bus.mem_wdata,    q[0].d);
            chk("mem_we",    32'(bus.mem_we),  32'(q[0].we));
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance the model.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input bit mr, input logic [31:0] la);
        bit   acc;
        bit   leg;
        exp_t e;
        bus.st_valid  = v;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.st_funct3 = f;
        bus.mem_ready = mr;
        bus.ld_addr   = la;
        #4;
        check_outputs();
        acc = v && (q.size() < DEPTH);
        leg = m_legal(f, a);
        if (mr && q.size() != 0) e = q.pop_front();
        if (acc && leg) begin
            e.a  = a[31:2];
            e.d  = m_wdata(f, d);
            e.we = m_we(f, a);
            q.push_back(e);
        end
        exp_err = acc && !leg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit mr);
        step(1'b0, 32'h0, 32'h0, 3'd0, mr, 32'hFFFF_FFF0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        int          r;

        exp_err       = 1'b0;
        rst_n         = 1'b0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.st_funct3 = '0;
        bus.mem_ready = 1'b0;
        bus.ld_addr   = 32'hFFFF_FFF0;
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Formatting with memory stalled, then drain one at a time.
        step(1'b1, 32'h1003, 32'hAABBCCDD, 3'd0, 1'b0, 32'h0);
        step(1'b1, 32'h2002, 32'h12345678, 3'd1, 1'b0, 32'h0);
        step(1'b1, 32'h3000, 32'hCAFEF00D, 3'd2, 1'b0, 32'h0);
        chk("fmt_sb_addr",  bus.mem_addr,        32'h0000_1000);
        chk("fmt_sb_we",    32'(bus.mem_we),     32'h8);
        chk("fmt_sb_wdata", bus.mem_wdata,       32'hDDDD_DDDD);
        idle(1'b1);
        chk("fmt_sh_addr",  bus.mem_addr,        32'h0000_2000);
        chk("fmt_sh_we",    32'(bus.mem_we),     32'hC);
        chk("fmt_sh_wdata", bus.mem_wdata,       32'h5678_5678);
        idle(1'b1);
        chk("fmt_sw_we",    32'(bus.mem_we),     32'hF);
        chk("fmt_sw_wdata", bus.mem_wdata,       32'hCAFE_F00D);
        idle(1'b1);
        idle(1'b1);

        // Misaligned and undefined stores: consumed, flagged, not queued.
        step(1'b1, 32'h4001, 32'h11111111, 3'd2, 1'b0, 32'h0);
        chk("misalign_sw_err", 32'(bus.st_error), 32'h1);
        step(1'b1, 32'h4003, 32'h22222222, 3'd1, 1'b0, 32'h0);
        chk("misalign_sh_err", 32'(bus.st_error), 32'h1);
        step(1'b1, 32'h4000, 32'h33333333, 3'd3, 1'b0, 32'h0);
        chk("undef_f3_err",    32'(bus.st_error), 32'h1);
        chk("undef_f3_count",  32'(bus.count),    32'h0);
        idle(1'b0);
        chk("err_one_cycle",   32'(bus.st_error), 32'h0);

        // Full / backpressure: 5 back-to-back, only 4 accepted.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h600 + 32'(4*i), 32'hA000_0000 + 32'(i), 3'd2, 1'b0, 32'h0);
        chk("full_ready", 32'(bus.st_ready), 32'h0);
        chk("full_count", 32'(bus.count),    32'h4);
        idle(1'b1);
        chk("after_drain_count", 32'(bus.count),    32'h3);
        chk("after_drain_ready", 32'(bus.st_ready), 32'h1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Wrap and concurrency: streaming with memory always ready.
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h100 + 32'(4*i), 32'hB000_0000 + 32'(i), 3'd2, 1'b1, 32'h0);
        chk("stream_count", 32'(bus.count), 32'h1);
        idle(1'b1);

        // Load hazard.
        step(1'b1, 32'h500, 32'h5555_5555, 3'd2, 1'b0, 32'h502);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h502);
        chk("hazard_hit", 32'(bus.ld_hazard), 32'h1);
        bus.ld_addr = 32'h504;
        #1;
        chk("hazard_other_word", 32'(bus.ld_hazard), 32'h0);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h502);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h502);
        chk("hazard_after_drain", 32'(bus.ld_hazard), 32'h0);

        // Reset mid-run with 3 entries queued.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h800 + 32'(4*i), 32'hC000_0000 + 32'(i), 3'd2, 1'b0, 32'h0);
        chk("pre_reset_count", 32'(bus.count), 32'h3);
        bus.st_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        q.delete();
        exp_err = 1'b0;
        chk("rst_count",     32'(bus.count),     32'h0);
        chk("rst_empty",     32'(bus.empty),     32'h1);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_st_ready",  32'(bus.st_ready),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      rf = 3'd2;
            else if (r < 7) rf = 3'd1;
            else if (r < 9) rf = 3'd0;
            else            rf = 3'($urandom_range(3, 7));
            ra = 32'h700 | 32'($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 4) == 0) ra = ra | 32'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 7, ra, $urandom, rf,
                 $urandom_range(0, 1) == 1, 32'h700 + 32'($urandom_range(0, 15)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        chk("final_empty", 32'(bus.empty), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart of the load-extension path in the CPU datapath.
- Accepts RISC-V stores (sb/sh/sw) from the execute/memory stage.
- Replicates store data into byte lanes and generates a 4-bit byte-write-enable.
- Rejects misaligned or undefined stores, queues legal stores in a small FIFO, and drains them to data memory/MMIO over a valid/ready port, with a load-hazard check against pending entries.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, range 2..16.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- st_valid  input  1  store request valid.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  32  byte address of the store.
- st_data  input  32  rs2 value, unaligned.
- st_funct3  input  3  store width: 000 sb, 001 sh, 010 sw.
- st_error  output  1  one-cycle pulse: the previously accepted store was misaligned or had an undefined funct3 and was dropped.
- mem_valid  output  1  head entry is presented to memory.
- mem_ready  input  1  memory accepts head entry.
- mem_addr  output  32  word address of the head entry, with bits [1:0] = 00.
- mem_wdata  output  32  lane-replicated write data.
- mem_we  output  4  byte write enables; bit i covers byte i (little-endian).
- ld_addr  input  32  address of a load in the same stage.
- ld_hazard  output  1  a pending entry targets the same word as ld_addr.
- count  output  CNT_W  number of pending entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous): pointers, count and entry valid bits clear; mem_valid=0, st_error=0, empty=1, st_ready=1, ld_hazard=0. All queued stores are discarded, including mid-drain. mem_addr, mem_wdata and mem_we are don't-care while mem_valid=0.
- Accept rule: a store is accepted when st_valid && st_ready, with st_ready = (count < DEPTH). st_ready is registered-state only and has no combinational path from mem_ready.
- A full buffer with a simultaneous drain still deasserts st_ready that cycle.
- Formatting of an accepted store, using a = st_addr[1:0]:
  - sb: wdata = {4{st_data[7:0]}}; we = 4'b0001 << a; always legal.
  - sh: wdata = {2{st_data[15:0]}}; we = a[1] ? 4'b1100 : 4'b0011; illegal if a[0]=1.
  - sw: wdata = st_data; we = 4'b1111; illegal if a != 0.
  - Any other funct3 is illegal.
- Illegal stores are consumed (handshake completes) but not enqueued. st_error pulses high for exactly the cycle after acceptance. Legal stores never raise st_error.
- Enqueue: the entry is written at wr_ptr with {addr[31:2], wdata, we}. wr_ptr increments modulo DEPTH.
- Latency: a store accepted in cycle N appears on mem_valid no earlier than cycle N+1.
- Drain: mem_valid = !empty. Outputs reflect the head entry at rd_ptr. On mem_valid && mem_ready, rd_ptr increments modulo DEPTH.
- Once asserted, mem_valid and the head outputs stay stable until the handshake completes. Entries drain strictly in acceptance order.
- Count update: count = count + enq - deq. Simultaneous enqueue and dequeue leave count unchanged.
- Simultaneous enqueue with an illegal store and dequeue: only the dequeue takes effect.
- Boundaries:
  - count never exceeds DEPTH and never underflows.
  - Wrap-around of both pointers is seamless.
  - mem_ready while empty is ignored.
- ld_hazard is combinational: 1 iff any valid entry has addr[31:2] == ld_addr[31:2]. It does not consider a store being accepted in the same cycle; the pipeline stalls the load until ld_hazard==0.

Test Plan:
- Reset/idle: rst_n low mid-run with 3 entries queued -> immediately count=0, empty=1, mem_valid=0, st_ready=1; after release, no stale writes appear.
- Formatting: hold mem_ready=0 and issue the following stores, then drain:
  - sb addr 0x1003 data 0xAABBCCDD -> mem_addr 0x1000, we 4'b1000, wdata 0xDDDDDDDD.
  - sh addr 0x2002 data 0x12345678 -> we 4'b1100, wdata 0x56785678.
  - sw addr 0x3000 -> we 4'b1111.
- Misalignment: sw addr 0x4001 and sh addr 0x4003 -> each accepted, st_error pulses one cycle later, count unchanged, nothing on mem.
- Undefined funct3=011 -> same as misalignment: accepted, st_error pulse, nothing enqueued.
- Full/backpressure: DEPTH=4, mem_ready=0, 5 back-to-back stores -> st_ready drops after the 4th, count=4. Then mem_ready=1 for one cycle -> first entry written, count=3, st_ready=1 next cycle. All 4 drain in order.
- Wrap and concurrency: mem_ready=1 continuously with 10 consecutive sw to 0x100,0x104,... -> each appears exactly once, in order, one per cycle after the first; count stays at 1.
- Hazard: queue sw 0x500 with mem_ready=0; ld_addr 0x502 -> ld_hazard=1; ld_addr 0x504 -> 0; after drain, ld_addr 0x502 -> 0.
